// File: rtl/dual_core_mem_arbiter_pkg.sv
// rtl/dual_core_mem_arbiter_pkg.sv - shared types and defaults for the dual-core RAM arbiter
//
// Purpose: owner encoding, default widths and a small helper used by the
// arbiter top level and the round-robin picker.
// Ports: none (package).
package mem_arb_pkg;

  localparam int DEF_AW       = 8;
  localparam int DEF_DW       = 8;
  localparam int DEF_HOLD_MAX = 4;

  typedef enum logic {
    OWN_C1 = 1'b0,
    OWN_C2 = 1'b1
  } owner_e;

  function automatic owner_e other_owner(owner_e o);
    return (o == OWN_C1) ? OWN_C2 : OWN_C1;
  endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_if.sv
// rtl/dual_core_mem_arbiter_if.sv - core request/response and RAM port bundle
//
// Purpose: groups both cores' req/gnt handshakes, read returns and the
// single RAM port so the arbiter and its environment share one connection.
// Ports (signals):
//   req1/2, we1/2, lock1/2, addr1/2, wdata1/2 : core requests
//   gnt1/2, rvalid1/2, rdata1/2               : grants and read returns
//   mem_addr, mem_data, mem_wren              : RAM port driven by the arbiter
//   mem_q                                     : RAM output, one cycle after address
// Modports: slave = arbiter side, master = cores + RAM side.
interface dual_core_mem_arbiter_if #(
  parameter int AW = mem_arb_pkg::DEF_AW,
  parameter int DW = mem_arb_pkg::DEF_DW
) ();

  logic          req1;
  logic          req2;
  logic          we1;
  logic          we2;
  logic          lock1;
  logic          lock2;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] wdata2;
  logic          gnt1;
  logic          gnt2;
  logic          rvalid1;
  logic          rvalid2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  modport slave (
    input  req1, req2, we1, we2, lock1, lock2,
    input  addr1, addr2, wdata1, wdata2, mem_q,
    output gnt1, gnt2, rvalid1, rvalid2, rdata1, rdata2,
    output mem_addr, mem_data, mem_wren
  );

  modport master (
    output req1, req2, we1, we2, lock1, lock2,
    output addr1, addr2, wdata1, wdata2, mem_q,
    input  gnt1, gnt2, rvalid1, rvalid2, rdata1, rdata2,
    input  mem_addr, mem_data, mem_wren
  );

endinterface

// File: rtl/dual_core_mem_arbiter_rr_pick2.sv
// rtl/dual_core_mem_arbiter_rr_pick2.sv - two-way round-robin picker with bounded lock
//
// Purpose: chooses one of two requesters per cycle. Alternates under
// contention, except that a locking last winner may keep ownership for at
// most HOLD_MAX consecutive contended grants.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req[1:0]        : requests (bit 0 = core 1, bit 1 = core 2)
//   lock[1:0]       : ownership-keep requests, same bit order
//   win_valid       : some core wins this cycle
//   win_id          : winning core (OWN_C1 / OWN_C2)
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic       win_valid,
  output owner_e     win_id
);

  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  owner_e        last_q;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic          contended;
  logic          last_lock;
  logic          keep_last;

  always_comb begin
    contended = req[0] & req[1];
    last_lock = (last_q == OWN_C1) ? lock[0] : lock[1];
    keep_last = last_lock && (hold_cnt < HW'(HOLD_MAX));
    win_valid = |req;
    if (contended) begin
      win_id = keep_last ? last_q : other_owner(last_q);
    end else if (req[0]) begin
      win_id = OWN_C1;
    end else begin
      win_id = OWN_C2;
    end
  end

  // Counts consecutive contended grants to the same core; an uncontended
  // grant or an idle cycle forgets the streak.
  always_comb begin
    hold_nxt = '0;
    if (contended) begin
      hold_nxt = (win_id == last_q) ? hold_cnt + HW'(1) : HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= OWN_C2;
      hold_cnt <= '0;
    end else begin
      if (win_valid) begin
        last_q <= win_id;
      end
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// rtl/dual_core_mem_arbiter.sv - arbiter sharing one synchronous RAM between two cores
//
// Purpose: grants one core per cycle (zero-latency gnt), muxes its request
// onto the RAM port and returns read data to that core one cycle later.
// Ports:
//   CLK    : clock, rising edge
//   rst_n  : asynchronous active-low reset; all outputs forced to 0 while low
//   bus    : dual_core_mem_arbiter_if.slave (core handshakes + RAM port)
module dual_core_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input logic                    CLK,
  input logic                    rst_n,
  dual_core_mem_arbiter_if.slave bus
);

  logic          win_valid;
  owner_e        win_id;
  logic          grant;
  logic          pick1;
  logic          pick2;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] data_sel;
  logic          we_sel;
  logic          rd_pend;
  owner_e        rd_owner;
  logic          rvalid1;
  logic          rvalid2;

  rr_pick2 #(
    .HOLD_MAX (HOLD_MAX)
  ) u_pick (
    .clk       (CLK),
    .rst_n     (rst_n),
    .req       ({bus.req2, bus.req1}),
    .lock      ({bus.lock2, bus.lock1}),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  // gnt is combinational from req, so it is gated with rst_n to keep every
  // output at zero while reset is held.
  always_comb begin
    grant    = win_valid & rst_n;
    pick1    = grant && (win_id == OWN_C1);
    pick2    = grant && (win_id == OWN_C2);
    addr_sel = '0;
    data_sel = '0;
    we_sel   = 1'b0;
    if (pick1) begin
      addr_sel = bus.addr1;
      data_sel = bus.wdata1;
      we_sel   = bus.we1;
    end else if (pick2) begin
      addr_sel = bus.addr2;
      data_sel = bus.wdata2;
      we_sel   = bus.we2;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_C1;
    end else begin
      rd_pend <= grant && !we_sel;
      if (grant && !we_sel) begin
        rd_owner <= win_id;
      end
    end
  end

  always_comb begin
    rvalid1 = rd_pend && (rd_owner == OWN_C1);
    rvalid2 = rd_pend && (rd_owner == OWN_C2);
  end

  assign bus.gnt1     = pick1;
  assign bus.gnt2     = pick2;
  assign bus.mem_addr = addr_sel;
  assign bus.mem_data = data_sel;
  assign bus.mem_wren = we_sel;
  assign bus.rvalid1  = rvalid1;
  assign bus.rvalid2  = rvalid2;
  assign bus.rdata1   = rvalid1 ? bus.mem_q : '0;
  assign bus.rdata2   = rvalid2 ? bus.mem_q : '0;

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb/tb_dual_core_mem_arbiter.sv - self-checking bench for dual_core_mem_arbiter
module tb_dual_core_mem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int HOLD_MAX = 4;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;

  dual_core_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dual_core_mem_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // synchronous single-port RAM environment
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_q;
  logic          ram_ready = 1'b0;
  logic          force_q   = 1'b0;
  logic [DW-1:0] q_junk    = '0;

  always @(posedge CLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
      ram_ready <= 1'b1;
    end else if (bus.mem_wren) begin
      ram[bus.mem_addr] <= bus.mem_data;
    end
    ram_q <= ram[bus.mem_addr];
  end

  assign bus.mem_q = force_q ? q_junk : ram_q;

  // stimulus registers
  bit          i_r1, i_r2, i_w1, i_w2, i_l1, i_l2;
  logic [7:0]  i_a1, i_a2, i_d1, i_d2;

  // reference model
  int          m_last, m_streak, m_owner;
  bit          m_pend;
  logic [7:0]  m_rd;
  logic [7:0]  sh [256];
  bit          cyc_valid;
  int          e_win;
  bit          e_both;
  logic        e_gnt1, e_gnt2, e_wren, e_rv1, e_rv2;
  logic [7:0]  e_addr, e_data, e_rd1, e_rd2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    m_last = 2; m_streak = 0; m_pend = 0; m_owner = 1; m_rd = '0;
    cyc_valid = 0; e_win = 0; e_both = 0;
    e_gnt1 = 0; e_gnt2 = 0; e_wren = 0; e_rv1 = 0; e_rv2 = 0;
    e_addr = '0; e_data = '0; e_rd1 = '0; e_rd2 = '0;
  endtask

  task automatic model_eval();
    bit lk;
    e_win = 0; e_gnt1 = 0; e_gnt2 = 0; e_wren = 0; e_rv1 = 0; e_rv2 = 0;
    e_addr = '0; e_data = '0; e_rd1 = '0; e_rd2 = '0;
    e_both = i_r1 && i_r2;
    if (rst_n !== 1'b1) begin
      cyc_valid = 0;
      return;
    end
    cyc_valid = 1;
    if (e_both) begin
      lk = (m_last == 1) ? i_l1 : i_l2;
      e_win = (lk && m_streak < HOLD_MAX) ? m_last : 3 - m_last;
    end else if (i_r1) e_win = 1;
    else if (i_r2) e_win = 2;
    e_gnt1 = (e_win == 1);
    e_gnt2 = (e_win == 2);
    if (e_win == 1) begin e_addr = i_a1; e_data = i_d1; e_wren = i_w1; end
    if (e_win == 2) begin e_addr = i_a2; e_data = i_d2; e_wren = i_w2; end
    e_rv1 = m_pend && m_owner == 1;
    e_rv2 = m_pend && m_owner == 2;
    if (e_rv1) e_rd1 = force_q ? q_junk : m_rd;
    if (e_rv2) e_rd2 = force_q ? q_junk : m_rd;
  endtask

  task automatic model_commit();
    if (!cyc_valid) return;
    if (e_win == 0 || !e_both) m_streak = 0;
    else if (e_win == m_last) m_streak++;
    else m_streak = 1;
    m_pend = 0;
    if (e_win != 0) begin
      m_last = e_win;
      if (e_wren) sh[e_addr] = e_data;
      else begin
        m_pend = 1; m_owner = e_win; m_rd = sh[e_addr];
      end
    end
  endtask

  task automatic cycle();
    model_commit();
    @(negedge CLK);
    bus.req1 = i_r1; bus.we1 = i_w1; bus.lock1 = i_l1; bus.addr1 = i_a1; bus.wdata1 = i_d1;
    bus.req2 = i_r2; bus.we2 = i_w2; bus.lock2 = i_l2; bus.addr2 = i_a2; bus.wdata2 = i_d2;
    #1;
    model_eval();
  endtask

  task automatic clear_inputs();
    i_r1 = 0; i_r2 = 0; i_w1 = 0; i_w2 = 0; i_l1 = 0; i_l2 = 0;
    i_a1 = '0; i_a2 = '0; i_d1 = '0; i_d2 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    force_q = 1'b0;
    clear_inputs();
    bus.req1 = 0; bus.req2 = 0; bus.we1 = 0; bus.we2 = 0; bus.lock1 = 0; bus.lock2 = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_r1 = 1; i_r2 = 1; i_w1 = 1; i_a1 = 8'h12; i_a2 = 8'h34; i_d1 = 8'h77;
    cycle();
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1 got=%b exp=0", bus.gnt1); end
    n_checks++; if (bus.gnt2 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt2 got=%b exp=0", bus.gnt2); end
    n_checks++; if (bus.mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%b exp=0", bus.mem_wren); end
    n_checks++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got=%h exp=00", bus.mem_addr); end
    n_checks++; if (bus.mem_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", bus.mem_data); end
    n_checks++; if ({bus.rvalid1, bus.rvalid2} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", {bus.rvalid1, bus.rvalid2}); end
    n_checks++; if ({bus.rdata1, bus.rdata2} !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", {bus.rdata1, bus.rdata2}); end
    do_reset();
  endtask

  task automatic test_reset_default();
    do_reset();
    i_r1 = 1; i_a1 = 8'h10; i_r2 = 1; i_a2 = 8'h20;
    cycle();
    n_checks++; if (bus.gnt1 !== 1'b1 || bus.gnt2 !== 1'b0) begin n_fail++; $display("FAIL dflt_c0_gnt got=%b%b exp=10", bus.gnt1, bus.gnt2); end
    n_checks++; if (bus.mem_addr !== 8'h10) begin n_fail++; $display("FAIL dflt_c0_addr got=%h exp=10", bus.mem_addr); end
    i_r1 = 0;
    cycle();
    n_checks++; if (bus.gnt2 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL dflt_c1_gnt got=%b%b exp=01", bus.gnt1, bus.gnt2); end
    n_checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 8'(16 * 37 + 11)) begin n_fail++; $display("FAIL dflt_c1_rd1 got=%b/%h exp=1/%h", bus.rvalid1, bus.rdata1, 8'(16 * 37 + 11)); end
    n_checks++; if (bus.rvalid2 !== 1'b0 || bus.rdata2 !== 8'h00) begin n_fail++; $display("FAIL dflt_c1_rd2 got=%b/%h exp=0/00", bus.rvalid2, bus.rdata2); end
    i_r2 = 0;
    cycle();
    n_checks++; if (bus.rvalid2 !== 1'b1 || bus.rdata2 !== 8'(32 * 37 + 11)) begin n_fail++; $display("FAIL dflt_c2_rd2 got=%b/%h exp=1/%h", bus.rvalid2, bus.rdata2, 8'(32 * 37 + 11)); end
    n_checks++; if (bus.rvalid1 !== 1'b0 || bus.rdata1 !== 8'h00) begin n_fail++; $display("FAIL dflt_c2_rd1 got=%b/%h exp=0/00", bus.rvalid1, bus.rdata1); end
  endtask

  task automatic test_write_read();
    do_reset();
    i_r2 = 1; i_w2 = 1; i_a2 = 8'h33; i_d2 = 8'hA5;
    cycle();
    n_checks++; if (bus.gnt2 !== 1'b1 || bus.mem_wren !== 1'b1) begin n_fail++; $display("FAIL wr_gnt_wren got=%b/%b exp=1/1", bus.gnt2, bus.mem_wren); end
    n_checks++; if (bus.mem_addr !== 8'h33 || bus.mem_data !== 8'hA5) begin n_fail++; $display("FAIL wr_port got=%h/%h exp=33/a5", bus.mem_addr, bus.mem_data); end
    n_checks++; if (bus.rvalid1 !== 1'b0 || bus.rvalid2 !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid got=%b%b exp=00", bus.rvalid1, bus.rvalid2); end
    i_w2 = 0;
    cycle();
    n_checks++; if (bus.gnt2 !== 1'b1 || bus.mem_wren !== 1'b0) begin n_fail++; $display("FAIL rd_gnt_wren got=%b/%b exp=1/0", bus.gnt2, bus.mem_wren); end
    n_checks++; if (bus.rvalid1 !== 1'b0 || bus.rvalid2 !== 1'b0) begin n_fail++; $display("FAIL rd_after_wr_rvalid got=%b%b exp=00", bus.rvalid1, bus.rvalid2); end
    i_r2 = 0;
    cycle();
    n_checks++; if (bus.rvalid2 !== 1'b1 || bus.rdata2 !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_data got=%b/%h exp=1/a5", bus.rvalid2, bus.rdata2); end
    n_checks++; if (bus.rvalid1 !== 1'b0 || bus.rdata1 !== 8'h00) begin n_fail++; $display("FAIL wr_rd_other got=%b/%h exp=0/00", bus.rvalid1, bus.rdata1); end
  endtask

  task automatic test_lock_cap();
    int exp_w [10];
    exp_w = '{1, 1, 1, 1, 2, 1, 2, 1, 2, 1};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      i_r1 = 1; i_r2 = 1; i_l1 = (c < 5); i_l2 = 0;
      i_a1 = 8'($urandom); i_a2 = 8'($urandom);
      cycle();
      n_checks++;
      if (bus.gnt1 !== (exp_w[c] == 1) || bus.gnt2 !== (exp_w[c] == 2)) begin
        n_fail++; $display("FAIL lock_cap c=%0d got=%b%b exp_core=%0d", c, bus.gnt1, bus.gnt2, exp_w[c]);
      end
    end
  endtask

  task automatic test_lock_no_contention();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      i_r1 = 1; i_l1 = 1; i_w1 = 0; i_a1 = 8'($urandom);
      cycle();
      n_checks++; if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL lock_solo_gnt c=%0d got=%b exp=1", c, bus.gnt1); end
      n_checks++; if (dut.u_pick.hold_cnt !== '0) begin n_fail++; $display("FAIL lock_solo_hold c=%0d got=%0d exp=0", c, dut.u_pick.hold_cnt); end
      n_checks++; if (bus.rvalid1 !== e_rv1 || bus.rdata1 !== e_rd1) begin n_fail++; $display("FAIL lock_solo_rd c=%0d got=%b/%h exp=%b/%h", c, bus.rvalid1, bus.rdata1, e_rv1, e_rd1); end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    i_r2 = 1; i_a2 = 8'h44;
    cycle();
    n_checks++; if (bus.gnt2 !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=1", bus.gnt2); end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.gnt2 !== 1'b0 || bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL midrst_drop got=%b/%h exp=0/00", bus.gnt2, bus.mem_addr); end
    i_r1 = 1; i_a1 = 8'h55;
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_checks++;
      if ({bus.gnt1, bus.gnt2, bus.rvalid1, bus.rvalid2, bus.mem_wren} !== 5'b0 || {bus.mem_addr, bus.mem_data, bus.rdata1, bus.rdata2} !== 32'h0) begin
        n_fail++; $display("FAIL midrst_zero c=%0d got=%b%b%b%b%b/%h exp=all0", c, bus.gnt1, bus.gnt2, bus.rvalid1, bus.rvalid2, bus.mem_wren, {bus.mem_addr, bus.mem_data, bus.rdata1, bus.rdata2});
      end
    end
    clear_inputs();
    cycle();
    rst_n = 1'b1;
    i_r1 = 1; i_a1 = 8'h55; i_r2 = 1; i_a2 = 8'h44;
    cycle();
    n_checks++; if (bus.gnt1 !== 1'b1 || bus.gnt2 !== 1'b0) begin n_fail++; $display("FAIL midrst_first got=%b%b exp=10", bus.gnt1, bus.gnt2); end
    n_checks++; if (bus.rvalid2 !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid2 got=%b exp=0", bus.rvalid2); end
  endtask

  task automatic test_idle();
    clear_inputs();
    cycle();
    for (int c = 0; c < 5; c++) begin
      force_q = 1'b1;
      q_junk  = 8'($urandom_range(1, 255));
      cycle();
      n_checks++; if (bus.mem_wren !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_data !== 8'h00) begin n_fail++; $display("FAIL idle_port c=%0d got=%b/%h/%h exp=0/00/00", c, bus.mem_wren, bus.mem_addr, bus.mem_data); end
      n_checks++; if (bus.rdata1 !== 8'h00 || bus.rdata2 !== 8'h00) begin n_fail++; $display("FAIL idle_rdata c=%0d got=%h/%h exp=00/00 q=%h", c, bus.rdata1, bus.rdata2, q_junk); end
      n_checks++; if (bus.gnt1 !== 1'b0 || bus.gnt2 !== 1'b0) begin n_fail++; $display("FAIL idle_gnt c=%0d got=%b%b exp=00", c, bus.gnt1, bus.gnt2); end
    end
    force_q = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!i_r1 || e_gnt1) begin
        i_r1 = ($urandom_range(0, 3) != 0); i_w1 = $urandom_range(0, 1);
        i_a1 = 8'($urandom_range(0, 15)); i_d1 = 8'($urandom);
      end
      if (!i_r2 || e_gnt2) begin
        i_r2 = ($urandom_range(0, 3) != 0); i_w2 = $urandom_range(0, 1);
        i_a2 = 8'($urandom_range(0, 15)); i_d2 = 8'($urandom);
      end
      i_l1 = ($urandom_range(0, 2) != 0);
      i_l2 = ($urandom_range(0, 2) == 0);
      cycle();
      n_checks++; if (bus.gnt1 !== e_gnt1 || bus.gnt2 !== e_gnt2) begin n_fail++; $display("FAIL rand_gnt c=%0d got=%b%b exp=%b%b", c, bus.gnt1, bus.gnt2, e_gnt1, e_gnt2); end
      n_checks++; if (bus.mem_addr !== e_addr || bus.mem_data !== e_data || bus.mem_wren !== e_wren) begin n_fail++; $display("FAIL rand_port c=%0d got=%h/%h/%b exp=%h/%h/%b", c, bus.mem_addr, bus.mem_data, bus.mem_wren, e_addr, e_data, e_wren); end
      n_checks++; if (bus.rvalid1 !== e_rv1 || bus.rdata1 !== e_rd1) begin n_fail++; $display("FAIL rand_rd1 c=%0d got=%b/%h exp=%b/%h", c, bus.rvalid1, bus.rdata1, e_rv1, e_rd1); end
      n_checks++; if (bus.rvalid2 !== e_rv2 || bus.rdata2 !== e_rd2) begin n_fail++; $display("FAIL rand_rd2 c=%0d got=%b/%h exp=%b/%h", c, bus.rvalid2, bus.rdata2, e_rv2, e_rd2); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sh[i] = 8'(i * 37 + 11);
    model_reset();
    test_reset();
    test_reset_default();
    test_write_read();
    test_lock_cap();
    test_lock_no_contention();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
